window_controller: RTL and testbench

Register-window manager for the SPARC V8 register file. Holds the current window pointer (CWP) that drives the register file's `current_window` input and the window invalid mask (WIM), and executes SAVE/RESTORE requests from the decode stage. A SAVE or RESTORE into an invalid window reports an overflow or underflow trap. With hardware spill/fill compiled in, the block instead moves locals and ins (r16–r31) between the register file and memory, rotates WIM, and then completes the operation.

---
 rtl/window_pkg.sv | 19 +
 rtl/window_controller_spill_seq.sv | 63 ++++++
 rtl/window_controller.sv | 160 ++++++++++++++++
 tb/tb_window_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_pkg.sv
// Shared types and constants for the SPARC V8 register-window controller.
// WINDOW_SPILL_FILL_EN adds the spill/fill sequencer states to the state enum.
package window_pkg;

  localparam int NWIN_DEFAULT = 4;
  localparam int SPILL_WORDS  = 16;
  localparam int SPILL_R_BASE = 16;

  localparam logic [1:0] TRAP_NONE = 2'd0;
  localparam logic [1:0] TRAP_OVF  = 2'd1;
  localparam logic [1:0] TRAP_UNF  = 2'd2;

`ifdef WINDOW_SPILL_FILL_EN
  typedef enum logic [2:0] {IDLE, RESP, SP_RD, SP_WR, FL_REQ, FL_WR, ROT} state_t;
`else
  typedef enum logic {IDLE, RESP} state_t;
`endif

endpackage

// File: rtl/window_controller_spill_seq.sv
// Spill/fill word sequencer: owns the word counter k, the captured data word and
// the register-file / memory handshake strobes. Only exists with WINDOW_SPILL_FILL_EN.
`ifdef WINDOW_SPILL_FILL_EN
module window_spill_seq
  import window_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          Clk,
  input  logic          Clr,
  input  state_t        state,
  input  logic [1:0]    win,
  input  logic [AW-1:0] spill_base,
  input  logic [31:0]   rf_rd_data,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack,
  output logic          k_last,
  output logic [1:0]    rf_window,
  output logic [4:0]    rf_r_num,
  output logic          rf_rd_en,
  output logic          rf_wr_en,
  output logic [31:0]   rf_wr_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata
);

  logic [3:0]  k_reg;
  logic [31:0] word_reg;
  logic        active;

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      k_reg    <= '0;
      word_reg <= '0;
    end else begin
      case (state)
        RESP:    k_reg <= '0;
        SP_RD:   word_reg <= rf_rd_data;
        SP_WR:   if (mem_ack) k_reg <= k_reg + 4'd1;
        FL_REQ:  if (mem_ack) word_reg <= mem_rdata;
        FL_WR:   k_reg <= k_reg + 4'd1;
        default: ;
      endcase
    end
  end

  // Address/number outputs are zeroed outside the word states so idle outputs stay quiet.
  assign active     = (state == SP_RD) || (state == SP_WR) || (state == FL_REQ) || (state == FL_WR);
  assign k_last     = (k_reg == 4'(SPILL_WORDS - 1));
  assign rf_window  = active ? win : 2'd0;
  assign rf_r_num   = active ? (5'(SPILL_R_BASE) + {1'b0, k_reg}) : 5'd0;
  assign rf_rd_en   = (state == SP_RD);
  assign rf_wr_en   = (state == FL_WR);
  assign rf_wr_data = (state == FL_WR) ? word_reg : 32'd0;
  assign mem_req    = (state == SP_WR) || (state == FL_REQ);
  assign mem_we     = (state == SP_WR);
  assign mem_addr   = mem_req ? (spill_base + AW'({k_reg, 2'b00})) : '0;
  assign mem_wdata  = (state == SP_WR) ? word_reg : 32'd0;

endmodule
`endif

// File: rtl/window_controller.sv
// SPARC V8 window manager: CWP/WIM registers and SAVE/RESTORE execution.
// WINDOW_SPILL_FILL_EN replaces overflow/underflow traps with a hardware spill/fill of r16-r31.
module window_controller
  import window_pkg::*;
#(
  parameter int NWIN = NWIN_DEFAULT,
  parameter int AW   = 32
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic            op_valid,
  input  logic            op_restore,
  output logic            op_ready,
  input  logic            cwp_wr_en,
  input  logic [1:0]      cwp_wr_data,
  input  logic            wim_wr_en,
  input  logic [NWIN-1:0] wim_wr_data,
  output logic [1:0]      current_window,
  output logic [NWIN-1:0] wim,
  output logic            done,
  output logic            trap,
  output logic [1:0]      trap_type
`ifdef WINDOW_SPILL_FILL_EN
  ,
  output logic [1:0]      rf_window,
  output logic [4:0]      rf_r_num,
  output logic            rf_rd_en,
  input  logic [31:0]     rf_rd_data,
  output logic            rf_wr_en,
  output logic [31:0]     rf_wr_data,
  input  logic [AW-1:0]   spill_base,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_rdata,
  input  logic            mem_ack
`endif
);

  localparam logic [NWIN-1:0] WIM_RESET = NWIN'(2);

  state_t          state_reg, state_next;
  logic [1:0]      cwp_reg;
  logic [NWIN-1:0] wim_reg;
  logic            restore_reg;
  logic            inv_reg;
  logic [1:0]      save_win, restore_win, new_win;
  logic            accept;

  assign save_win    = (cwp_reg == 2'd0) ? 2'(NWIN - 1) : cwp_reg - 2'd1;
  assign restore_win = (cwp_reg == 2'(NWIN - 1)) ? 2'd0 : cwp_reg + 2'd1;
  assign new_win     = op_restore ? restore_win : save_win;
  assign op_ready    = (state_reg == IDLE) && !cwp_wr_en && !wim_wr_en;
  assign accept      = op_valid && op_ready;

  assign current_window = cwp_reg;
  assign wim            = wim_reg;

`ifdef WINDOW_SPILL_FILL_EN
  logic [1:0] new_reg;
  logic       k_last;

  window_spill_seq #(.AW(AW)) u_seq (
    .Clk        (Clk),
    .Clr        (Clr),
    .state      (state_reg),
    .win        (new_reg),
    .spill_base (spill_base),
    .rf_rd_data (rf_rd_data),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .k_last     (k_last),
    .rf_window  (rf_window),
    .rf_r_num   (rf_r_num),
    .rf_rd_en   (rf_rd_en),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_data (rf_wr_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata)
  );
`endif

  // A valid op commits CWP on the accept edge so it is visible alongside done.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_reg   <= IDLE;
      cwp_reg     <= '0;
      wim_reg     <= WIM_RESET;
      restore_reg <= 1'b0;
      inv_reg     <= 1'b0;
`ifdef WINDOW_SPILL_FILL_EN
      new_reg     <= '0;
`endif
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE) begin
        if (cwp_wr_en) cwp_reg <= cwp_wr_data;
        if (wim_wr_en) wim_reg <= wim_wr_data;
        if (accept) begin
          restore_reg <= op_restore;
          inv_reg     <= wim_reg[new_win];
`ifdef WINDOW_SPILL_FILL_EN
          new_reg     <= new_win;
`endif
          if (!wim_reg[new_win]) cwp_reg <= new_win;
        end
      end
`ifdef WINDOW_SPILL_FILL_EN
      if (state_reg == ROT) begin
        cwp_reg <= new_reg;
        wim_reg <= restore_reg ? {wim_reg[NWIN-2:0], wim_reg[NWIN-1]}
                               : {wim_reg[0], wim_reg[NWIN-1:1]};
      end
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    trap       = 1'b0;
    trap_type  = TRAP_NONE;
    case (state_reg)
      IDLE: if (accept) state_next = RESP;
      RESP: begin
`ifdef WINDOW_SPILL_FILL_EN
        if (inv_reg) begin
          state_next = restore_reg ? FL_REQ : SP_RD;
        end else begin
          done       = 1'b1;
          state_next = IDLE;
        end
`else
        state_next = IDLE;
        if (inv_reg) begin
          trap      = 1'b1;
          trap_type = restore_reg ? TRAP_UNF : TRAP_OVF;
        end else begin
          done = 1'b1;
        end
`endif
      end
`ifdef WINDOW_SPILL_FILL_EN
      SP_RD:  state_next = SP_WR;
      SP_WR:  if (mem_ack) state_next = k_last ? ROT : SP_RD;
      FL_REQ: if (mem_ack) state_next = FL_WR;
      FL_WR:  state_next = k_last ? ROT : FL_REQ;
      ROT: begin
        done       = 1'b1;
        state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_window_controller.sv
// Randomised self-checking bench for window_controller with a cycle-level window model.
// Spill/fill scenarios are exercised when WINDOW_SPILL_FILL_EN is defined.
`timescale 1ns/1ps
module tb_window_controller;

  logic       Clk = 1'b0;
  logic       Clr = 1'b0;
  logic       op_valid = 1'b0, op_restore = 1'b0;
  logic       cwp_wr_en = 1'b0, wim_wr_en = 1'b0;
  logic [1:0] cwp_wr_data = 2'd0;
  logic [3:0] wim_wr_data = 4'd0;
  logic       op_ready, done, trap;
  logic [1:0] current_window, trap_type;
  logic [3:0] wim;

`ifdef WINDOW_SPILL_FILL_EN
  logic [1:0]  rf_window;
  logic [4:0]  rf_r_num;
  logic        rf_rd_en, rf_wr_en;
  logic [31:0] rf_rd_data, rf_wr_data;
  logic [31:0] spill_base = 32'h0000_1000;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack = 1'b1;

  // Mock register file and memory: data encodes where it came from.
  assign rf_rd_data = {16'hBEEF, 6'd0, rf_window, 3'd0, rf_r_num};
  assign mem_rdata  = {16'h5A5A, mem_addr[15:0]};

  logic [31:0] wr_addr [32];
  logic [31:0] wr_data [32];
  logic [4:0]  wr_rnum [32];
  logic [1:0]  wr_win  [32];
  int          wr_n = 0;

  always @(posedge Clk) begin
    if (mem_req && mem_we && mem_ack && wr_n < 32) begin
      wr_addr[wr_n] <= mem_addr;
      wr_data[wr_n] <= mem_wdata;
      wr_rnum[wr_n] <= rf_r_num;
      wr_win[wr_n]  <= rf_window;
      wr_n          <= wr_n + 1;
    end
  end
`endif

  window_controller dut (
    .Clk            (Clk),
    .Clr            (Clr),
    .op_valid       (op_valid),
    .op_restore     (op_restore),
    .op_ready       (op_ready),
    .cwp_wr_en      (cwp_wr_en),
    .cwp_wr_data    (cwp_wr_data),
    .wim_wr_en      (wim_wr_en),
    .wim_wr_data    (wim_wr_data),
    .current_window (current_window),
    .wim            (wim),
    .done           (done),
    .trap           (trap),
    .trap_type      (trap_type)
`ifdef WINDOW_SPILL_FILL_EN
    ,
    .rf_window      (rf_window),
    .rf_r_num       (rf_r_num),
    .rf_rd_en       (rf_rd_en),
    .rf_rd_data     (rf_rd_data),
    .rf_wr_en       (rf_wr_en),
    .rf_wr_data     (rf_wr_data),
    .spill_base     (spill_base),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack)
`endif
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // Model state: architectural CWP/WIM plus the response expected in the next cycle.
  int m_cwp = 0, m_wim = 2, m_tt = 0;
  bit m_busy = 0, m_done = 0, m_trap = 0;
  bit last_ready = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cwp = 0; m_wim = 2; m_tt = 0;
    m_busy = 0; m_done = 0; m_trap = 0;
  endtask

  // One clock cycle: compare, drive inputs, compare op_ready, advance the model.
  task automatic step(input bit v, input bit r, input bit cw, input int cd,
                      input bit ww, input int wd);
    bit exp_ready;
    int nw;
    chk("cwp", current_window, m_cwp);
    chk("wim", wim, m_wim);
    chk("done", done, m_done);
    chk("trap", trap, m_trap);
    chk("trap_type", trap_type, m_tt);
    op_valid = v; op_restore = r;
    cwp_wr_en = cw; cwp_wr_data = cd[1:0];
    wim_wr_en = ww; wim_wr_data = wd[3:0];
    #1;
    exp_ready = !m_busy && !cw && !ww;
    last_ready = op_ready;
    chk("op_ready", op_ready, exp_ready);
    m_done = 0; m_trap = 0; m_tt = 0;
    if (m_busy) begin
      m_busy = 0;
    end else begin
      if (cw) m_cwp = cd;
      if (ww) m_wim = wd;
      if (v && exp_ready) begin
        nw = r ? (m_cwp + 1) % 4 : (m_cwp + 3) % 4;
        m_busy = 1;
        if (((m_wim >> nw) & 1) != 0) begin
          m_trap = 1;
          m_tt = r ? 2 : 1;
          $display("op %s cwp=%0d new=%0d wim=%0h -> trap type %0d",
                   r ? "RESTORE" : "SAVE", m_cwp, nw, m_wim, m_tt);
        end else begin
          $display("op %s cwp=%0d new=%0d wim=%0h -> done",
                   r ? "RESTORE" : "SAVE", m_cwp, nw, m_wim);
          m_cwp = nw;
          m_done = 1;
        end
      end
    end
    @(negedge Clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit reached;
    repeat (2) @(negedge Clk);
    chk("rst_cwp", current_window, 0);
    chk("rst_wim", wim, 4'b0010);
    chk("rst_ready", op_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_trap", trap, 0);
    chk("rst_trap_type", trap_type, 0);
`ifdef WINDOW_SPILL_FILL_EN
    chk("rst_mem_req", mem_req, 0);
`endif
    Clr = 1'b1;
    @(negedge Clk);
    model_reset();

`ifndef WINDOW_SPILL_FILL_EN
    step(1, 0, 0, 0, 0, 0);
    chk("save1_cwp_lit", current_window, 3);
    chk("save1_done_lit", done, 1);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("save2_cwp_lit", current_window, 2);
    chk("save2_done_lit", done, 1);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("save3_trap_lit", trap, 1);
    chk("save3_type_lit", trap_type, 1);
    chk("save3_cwp_lit", current_window, 2);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 8);
    step(1, 1, 0, 0, 0, 0);
    chk("unf_trap_lit", trap, 1);
    chk("unf_type_lit", trap_type, 2);
    chk("unf_cwp_lit", current_window, 2);
    step(0, 0, 0, 0, 0, 0);
`endif

    step(1, 0, 1, 1, 0, 0);
    chk("cfg_prio_ready_lit", last_ready, 0);
    chk("cfg_prio_cwp_lit", current_window, 1);
    chk("cfg_prio_done_lit", done, 0);
    step(0, 0, 0, 0, 0, 0);

`ifdef WINDOW_SPILL_FILL_EN
    // Overflow spill of window 1 from CWP 2 with mem_ack tied high.
    step(0, 0, 1, 2, 0, 0);
    op_valid = 1'b1; op_restore = 1'b0;
    #1;
    chk("spill_accept_ready", op_ready, 1);
    @(negedge Clk);
    op_valid = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("spill_done_latency", n, 34);
    chk("spill_no_trap", trap, 0);
    @(negedge Clk);
    chk("spill_cwp", current_window, 1);
    chk("spill_wim", wim, 4'b0001);
    chk("spill_word_count", wr_n, 16);
    for (int k = 0; k < 16; k++) begin
      chk("spill_addr", wr_addr[k], 32'h1000 + 4 * k);
      chk("spill_rnum", wr_rnum[k], 16 + k);
      chk("spill_win", wr_win[k], 1);
      chk("spill_data", wr_data[k], 32'hBEEF_0000 | (1 << 8) | (16 + k));
    end
    $display("spill complete: %0d words written", wr_n);
    m_cwp = 1; m_wim = 1; m_busy = 0; m_done = 0; m_trap = 0; m_tt = 0;

    // Underflow fill of window 2, abandoned by reset during the 5th word.
    step(0, 0, 0, 0, 1, 4);
    op_valid = 1'b1; op_restore = 1'b1;
    @(negedge Clk);
    op_valid = 1'b0;
    n = 0;
    reached = 0;
    while (n < 100 && !reached) begin
      if (mem_req && !mem_we && mem_addr == 32'h1010) reached = 1;
      else begin
        @(negedge Clk);
        n++;
      end
    end
    chk("fill_5th_word_reached", reached, 1);
    Clr = 1'b0;
    #1;
    chk("fill_rst_mem_req", mem_req, 0);
    chk("fill_rst_rf_wr_en", rf_wr_en, 0);
    chk("fill_rst_cwp", current_window, 0);
    chk("fill_rst_wim", wim, 4'b0010);
    chk("fill_rst_ready", op_ready, 1);
    $display("fill abandoned by reset at word 5");
    @(negedge Clk);
    Clr = 1'b1;
    @(negedge Clk);
    model_reset();
    step(0, 0, 0, 0, 1, 0);
`endif

    for (int i = 0; i < 600; i++) begin
      int wd;
`ifdef WINDOW_SPILL_FILL_EN
      wd = 0;
`else
      wd = $urandom_range(0, 15);
`endif
      step($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0, $urandom_range(0, 3),
           $urandom_range(0, 9) == 0, wd);
    end
    step(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
